// File: rtl/mem_port_sched.sv
// Shared data-memory port scheduler: fetch reads vs execute scalar/vector ld/st.
// Optional FETCH_STARVE_GUARD_EN forces a fetch grant after 7 starved cycles.
module mem_port_sched #(
    parameter int VLEN   = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_req,
    input  logic [ADDR_W-1:0]        f_addr,
    output logic                     f_gnt,
    output logic                     f_rvalid,
    output logic [DATA_W-1:0]        f_rdata,
    input  logic                     x_req,
    input  logic                     x_we,
    input  logic                     x_vec,
    input  logic [ADDR_W-1:0]        x_addr,
    input  logic [VLEN*DATA_W-1:0]   x_wdata,
    output logic                     x_gnt,
    output logic                     x_busy,
    output logic                     x_done,
    output logic [VLEN*DATA_W-1:0]   x_rdata,
    output logic [ADDR_W-1:0]        mem_raddr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     mem_wen,
    output logic [ADDR_W-1:0]        mem_waddr,
    output logic [DATA_W-1:0]        mem_wdata
);

    localparam int BW = $clog2(VLEN);

    typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;

    state_t                  state;
    state_t                  stateNext;
    logic [BW-1:0]           beat;
    logic [BW-1:0]           lastBeat;
    logic                    atLast;
    logic [ADDR_W-1:0]       baseAddr;
    logic [ADDR_W-1:0]       curAddr;
    logic                    isWe;
    logic                    isVec;
    logic [VLEN*DATA_W-1:0]  wdataReg;
    logic [VLEN*DATA_W-1:0]  rdataReg;
    logic                    capPend;
    logic [BW-1:0]           capLane;
    logic                    fRvalid;
    logic                    fetchForce;

    assign lastBeat = isVec ? BW'(VLEN - 1) : '0;
    assign atLast   = (beat == lastBeat);
    assign curAddr  = baseAddr + ADDR_W'(beat);

`ifdef FETCH_STARVE_GUARD_EN
    logic [2:0] starveCnt;

    assign fetchForce = (starveCnt == 3'd7);

    // Saturates so a long vector transfer cannot wrap the count back down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (f_gnt) begin
            starveCnt <= '0;
        end else if (f_req && starveCnt != 3'd7) begin
            starveCnt <= starveCnt + 3'd1;
        end
    end
`else
    assign fetchForce = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        x_gnt     = 1'b0;
        f_gnt     = 1'b0;
        x_busy    = 1'b0;
        x_done    = 1'b0;
        mem_raddr = '0;
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (!rst) begin
                    if (f_req && fetchForce) begin
                        f_gnt     = 1'b1;
                        mem_raddr = f_addr;
                    end else if (x_req) begin
                        x_gnt     = 1'b1;
                        stateNext = XFER;
                    end else if (f_req) begin
                        f_gnt     = 1'b1;
                        mem_raddr = f_addr;
                    end
                end
            end
            XFER: begin
                x_busy = 1'b1;
                if (isWe) begin
                    mem_wen   = 1'b1;
                    mem_waddr = curAddr;
                    mem_wdata = wdataReg[DATA_W*beat +: DATA_W];
                end else begin
                    mem_raddr = curAddr;
                end
                if (atLast) begin
                    stateNext = isWe ? DONE : WAIT;
                end
            end
            WAIT: begin
                x_busy    = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                x_done    = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            baseAddr <= '0;
            isWe     <= 1'b0;
            isVec    <= 1'b0;
            wdataReg <= '0;
            rdataReg <= '0;
            capPend  <= 1'b0;
            capLane  <= '0;
            fRvalid  <= 1'b0;
        end else begin
            state   <= stateNext;
            fRvalid <= f_gnt;
            capPend <= 1'b0;
            // Read data for the beat issued last cycle lands now
            if (capPend) begin
                rdataReg[DATA_W*capLane +: DATA_W] <= mem_rdata;
            end
            if (x_gnt) begin
                baseAddr <= x_addr;
                isWe     <= x_we;
                isVec    <= x_vec;
                wdataReg <= x_wdata;
                rdataReg <= '0;
                beat     <= '0;
            end
            if (state == XFER) begin
                beat <= beat + BW'(1);
                if (!isWe) begin
                    capPend <= 1'b1;
                    capLane <= beat;
                end
            end
        end
    end

    assign f_rvalid = fRvalid;
    assign f_rdata  = fRvalid ? mem_rdata : '0;
    assign x_rdata  = rdataReg;

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: transaction-level model plus directed and random traffic.
// Build with +define+FETCH_STARVE_GUARD_EN to exercise the starvation guard.
module tb_mem_port_sched;

    localparam int VLEN = 4;
    localparam int DW   = 16;
    localparam int AW   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_req;
    logic [AW-1:0]     f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DW-1:0]     f_rdata;
    logic              x_req;
    logic              x_we;
    logic              x_vec;
    logic [AW-1:0]     x_addr;
    logic [VLEN*DW-1:0] x_wdata;
    logic              x_gnt;
    logic              x_busy;
    logic              x_done;
    logic [VLEN*DW-1:0] x_rdata;
    logic [AW-1:0]     mem_raddr;
    logic [DW-1:0]     mem_rdata;
    logic              mem_wen;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;

    always #5 clk = ~clk;

    mem_port_sched #(.VLEN(VLEN), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .x_req(x_req), .x_we(x_we), .x_vec(x_vec), .x_addr(x_addr),
        .x_wdata(x_wdata), .x_gnt(x_gnt), .x_busy(x_busy),
        .x_done(x_done), .x_rdata(x_rdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    // Memory the DUT talks to, 1-cycle read latency
    logic [DW-1:0] mem    [0:65535];
    logic [DW-1:0] refMem [0:65535];

    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level reference model
    int              mT = -1;
    int              mN;
    bit              mWe;
    logic [AW-1:0]   mBase;
    logic [63:0]     mWdata;
    logic [63:0]     mExpRd;
    logic [63:0]     mHold = '0;
    int              mCnt = 0;
    bit              mPrevFg = 0;
    logic [DW-1:0]   mPrevFd = '0;
    bit              lastXg = 0;
    bit              lastFg = 0;

`ifdef FETCH_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    always @(negedge clk) begin
        logic          eXg, eFg, eBusy, eDone, eWen, eFrv;
        logic [AW-1:0] eRaddr, eWaddr, a;
        logic [DW-1:0] eWdata, eFrd;
        if (rst) begin
            mT      = -1;
            mCnt    = 0;
            mPrevFg = 0;
            mHold   = '0;
            lastXg  = 0;
            lastFg  = 0;
        end else begin
            eXg = 0; eFg = 0; eBusy = 0; eDone = 0; eWen = 0;
            eRaddr = '0; eWaddr = '0; eWdata = '0; a = '0;
            eFrv = mPrevFg;
            eFrd = mPrevFg ? mPrevFd : '0;
            if (mT < 0) begin
                if (GUARD && mCnt == 7 && f_req) eFg = 1;
                else if (x_req) eXg = 1;
                else if (f_req) eFg = 1;
                if (eFg) eRaddr = f_addr;
                chk("x_rdata_hold", x_rdata, mHold);
            end else if (mT <= mN) begin
                a = mBase + AW'(mT - 1);
                eBusy = 1;
                if (mWe) begin
                    eWen   = 1;
                    eWaddr = a;
                    eWdata = mWdata[(mT-1)*DW +: DW];
                end else begin
                    eRaddr = a;
                end
            end else if (!mWe && mT == mN + 1) begin
                eBusy = 1;
            end else begin
                eDone = 1;
                chk("x_rdata_done", x_rdata, mExpRd);
            end
            chk("x_gnt", x_gnt, eXg);
            chk("f_gnt", f_gnt, eFg);
            chk("x_busy", x_busy, eBusy);
            chk("x_done", x_done, eDone);
            chk("mem_wen", mem_wen, eWen);
            chk("mem_waddr", mem_waddr, eWaddr);
            chk("mem_wdata", mem_wdata, eWdata);
            chk("mem_raddr", mem_raddr, eRaddr);
            chk("f_rvalid", f_rvalid, eFrv);
            chk("f_rdata", f_rdata, eFrd);
            // advance the model
            if (eWen) refMem[eWaddr] = eWdata;
            mPrevFg = eFg;
            if (eFg) mPrevFd = refMem[f_addr];
            if (eFg) mCnt = 0;
            else if (f_req && mCnt < 7) mCnt++;
            lastXg = eXg;
            lastFg = eFg;
            if (mT < 0) begin
                if (eXg) begin
                    mT     = 1;
                    mWe    = x_we;
                    mN     = x_vec ? VLEN : 1;
                    mBase  = x_addr;
                    mWdata = x_wdata;
                    mExpRd = '0;
                    if (!x_we)
                        for (int k = 0; k < mN; k++)
                            mExpRd[k*DW +: DW] = refMem[x_addr + AW'(k)];
                end
            end else if (eDone) begin
                mT    = -1;
                mHold = mExpRd;
            end else begin
                mT++;
            end
        end
    end

    task automatic doX(input bit we, input bit vec, input logic [AW-1:0] addr,
                       input logic [63:0] wd, output int lat);
        int n;
        x_req = 1; x_we = we; x_vec = vec; x_addr = addr; x_wdata = wd;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!lastXg && n < 50);
        if (n >= 50) chk("x_accept_timeout", 0, 1);
        @(posedge clk); #1;
        x_req = 0;
        lat = 0;
        do begin
            @(negedge clk); #1;
            lat++;
        end while (!x_done && lat < 30);
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] v);
        mem[addr]    = v;
        refMem[addr] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int fgAt;
        bit seen;
        logic [DW-1:0] v;
        rst = 1; f_req = 0; f_addr = '0;
        x_req = 1; x_we = 0; x_vec = 0; x_addr = '0; x_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            v = DW'($urandom);
            mem[i]    = v;
            refMem[i] = v;
        end
        @(negedge clk); #1;
        chk("rst_x_gnt", x_gnt, 0);
        chk("rst_x_busy", x_busy, 0);
        chk("rst_x_done", x_done, 0);
        chk("rst_x_rdata", x_rdata, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_f_rvalid", f_rvalid, 0);
        @(posedge clk); #1;
        x_req = 0;
        rst = 0;
        @(posedge clk); #1;

        // scalar load
        preload(16'h0010, 16'hBEEF);
        doX(0, 0, 16'h0010, 64'h0, lat);
        chk("sload_lat", lat, 3);
        chk("sload_rdata", x_rdata, 64'h0000_0000_0000_BEEF);

        // vector store across the address wrap
        doX(1, 1, 16'hFFFE, 64'h0004_0003_0002_0001, lat);
        chk("vstore_lat", lat, 5);
        chk("vstore_m_fffe", mem[16'hFFFE], 16'h0001);
        chk("vstore_m_ffff", mem[16'hFFFF], 16'h0002);
        chk("vstore_m_0000", mem[16'h0000], 16'h0003);
        chk("vstore_m_0001", mem[16'h0001], 16'h0004);

        // vector load
        for (int i = 0; i < 4; i++) preload(16'h0020 + AW'(i), 16'h00A0 + DW'(i));
        doX(0, 1, 16'h0020, 64'h0, lat);
        chk("vload_lat", lat, 6);
        chk("vload_rdata", x_rdata, 64'h00A3_00A2_00A1_00A0);

        // x beats fetch when both request; fetch goes the first idle cycle after
        f_req = 1; f_addr = 16'h0010;
        doX(1, 0, 16'h0040, 64'h1234, lat);
        chk("prio_lat", lat, 2);
        @(negedge clk); #1;
        chk("prio_f_gnt", f_gnt, 1);
        @(posedge clk); #1;
        f_req = 0;
        @(negedge clk); #1;
        chk("prio_f_rvalid", f_rvalid, 1);
        chk("prio_f_rdata", f_rdata, 16'hBEEF);
        @(posedge clk); #1;

        // reset during beat 2 of a vector store
        for (int i = 0; i < 4; i++) preload(16'h0100 + AW'(i), 16'h0000);
        x_req = 1; x_we = 1; x_vec = 1; x_addr = 16'h0100;
        x_wdata = 64'h0044_0033_0022_0011;
        @(posedge clk); #1;
        x_req = 0;
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("mrst_x_busy", x_busy, 0);
        chk("mrst_mem_wen", mem_wen, 0);
        chk("mrst_mem_waddr", mem_waddr, 0);
        chk("mrst_x_done", x_done, 0);
        chk("mrst_x_rdata", x_rdata, 0);
        @(posedge clk); #3;
        rst = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("mrst_m_0100", mem[16'h0100], 16'h0011);
        chk("mrst_m_0101", mem[16'h0101], 16'h0000);
        chk("mrst_m_0102", mem[16'h0102], 16'h0000);
        @(posedge clk); #1;

        // back-to-back scalar stores against a held fetch request
        f_req = 1; f_addr = 16'h0020;
        x_req = 1; x_we = 1; x_vec = 0; x_addr = 16'h0300; x_wdata = 64'h5A5A;
        seen = 0; fgAt = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            if (!seen && f_gnt) begin
                seen = 1;
                fgAt = n;
            end
        end
`ifdef FETCH_STARVE_GUARD_EN
        chk("starve_grant_cycle", fgAt, 9);
`else
        chk("starve_no_grant", seen, 0);
`endif
        @(posedge clk); #1;
        x_req = 0; f_req = 0;
        repeat (6) @(posedge clk);
        #1;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!x_req || lastXg) begin
                x_req   = ($urandom_range(2) == 0);
                x_we    = 1'($urandom);
                x_vec   = 1'($urandom);
                x_addr  = ($urandom_range(3) == 0) ? 16'hFFFC + AW'($urandom_range(3))
                                                   : AW'($urandom);
                x_wdata = {$urandom, $urandom};
            end
            if (!f_req || lastFg) begin
                f_req  = 1'($urandom);
                f_addr = AW'($urandom);
            end
            @(posedge clk); #1;
        end
        x_req = 0; f_req = 0;
        repeat (10) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
